alu_control_sequencer: RTL
==========================

ALU_CONTROL_SEQUENCER -- requirements
Module: alu_control_sequencer

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 4, meaning cycles from MULT acceptance to HI/LO write (legal 1..64).
REQ-002 SHALL have parameter DIV_CYCLES, default 32, meaning cycles from DIV acceptance to HI/LO write (legal 1..64).
REQ-003 SHALL have parameter ALU_CTRL_W, default 4, meaning width of ALU control codes.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous active-low reset.
REQ-006 SHALL have port issue  input  1  instruction on aluOp/func valid this cycle.
REQ-007 SHALL have port aluOp  input  2  0 none, 1 R-type, 2 addi, 3 beq/bne.
REQ-008 SHALL have port func  input  6  R-type function field.
REQ-009 SHALL have port aluControl  output  ALU_CTRL_W  single-cycle ALU operation for the current instruction.
REQ-010 SHALL have port mdControl  output  ALU_CTRL_W  operation held for the multi-cycle multiply/divide unit.
REQ-011 SHALL have port regHiLoWrite  output  1  one-cycle HI/LO write strobe.
REQ-012 SHALL have port busy  output  1  multiply/divide in flight, not in final cycle.
REQ-013 SHALL have port stall  output  1  current issued instruction must be held by the core.

Function
REQ-014 aluControl SHALL be combinational: aluOp 1 decodes ADD/SUB/AND/OR/SLT to matching codes, MULT/DIV/MFHI/MFLO to ALU_MULT/ALU_DIV/ALU_MFHI/ALU_MFLO, others ALU_ZERO; aluOp 2 ALU_ADD; aluOp 3 ALU_SUB; aluOp 0 ALU_ZERO.
REQ-015 FSM states SHALL be IDLE and RUN; counter width clog2(65).
REQ-016 MULT/DIV SHALL be accepted when issue=1, aluOp=1, and busy=0; acceptance loads counter with MULT_CYCLES-1 or DIV_CYCLES-1, latches mdControl, enters RUN.
REQ-017 In RUN the counter SHALL decrement each cycle while nonzero; busy = (RUN and counter!=0).
REQ-018 regHiLoWrite SHALL be 1 exactly in the RUN cycle with counter==0, i.e. the Nth cycle after the acceptance edge; next state IDLE unless a new MULT/DIV is accepted that cycle (back-to-back, re-enter RUN).
REQ-019 mdControl SHALL hold the latched code through RUN and return to ALU_ZERO on entering IDLE.
REQ-020 stall SHALL be 1 when issue=1 and (MULT/DIV with busy=1, or MFHI/MFLO with state RUN, including the write cycle); else 0.
REQ-021 A stalled instruction SHALL not change state; aluControl SHALL output ALU_ZERO while stall=1.
REQ-022 Non-HI/LO instructions SHALL decode normally during RUN with stall=0.
REQ-023 issue=0 SHALL force stall=0 and aluControl=ALU_ZERO and prevent acceptance.

Reset
REQ-024 reset=0 SHALL asynchronously force IDLE, counter 0, mdControl ALU_ZERO, regHiLoWrite 0, busy 0, stall 0.
REQ-025 Reset mid-RUN SHALL abort without any regHiLoWrite pulse; first acceptance allowed on the first edge after release.

Configuration
REQ-026 Macro ALU_EXT_FUNC_EN defined SHALL add decode of XOR, NOR, SLTU (single-cycle) and MULTU, DIVU (multi-cycle, same latencies, codes ALU_MULTU/ALU_DIVU); undefined, these funcs SHALL decode as ALU_ZERO and never start RUN.

Structure
REQ-027 ALU codes, function codes and the FSM state enum SHALL live in the shared packages libAlu and libFunctions.
REQ-028 Combinational decode SHALL be sub-module alu_func_decoder; FSM and counter stay in the top.

Verification
REQ-029 reset low mid-RUN of DIV (count 10) -> all outputs 0/ALU_ZERO immediately, no strobe after release.
REQ-030 issue MULT (aluOp 1, func 0x18), MULT_CYCLES=4 -> regHiLoWrite high only in 4th cycle after acceptance, mdControl=ALU_MULT cycles 1-4.
REQ-031 MFLO (0x12) issued 1 cycle after MULT -> stall=1 until and including write cycle, decodes ALU_MFLO the cycle after.
REQ-032 ADD (0x20) during DIV RUN -> aluControl=ALU_ADD, stall=0, counter unaffected.
REQ-033 DIV issued in write cycle of MULT -> accepted, strobe once for MULT, then after DIV_CYCLES again.
REQ-034 MULT_CYCLES=1 -> strobe in cycle immediately after acceptance; func 0x26 without ALU_EXT_FUNC_EN -> ALU_ZERO, with -> ALU_XOR.

Source files
------------

// File: rtl/libAlu.sv
// Shared ALU operation codes, sequencer state type and counter sizing.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package libAlu;

    localparam int ALU_CODE_W = 4;
    typedef logic [ALU_CODE_W-1:0] alu_code_t;

    localparam alu_code_t ALU_ZERO  = 4'd0;
    localparam alu_code_t ALU_ADD   = 4'd1;
    localparam alu_code_t ALU_SUB   = 4'd2;
    localparam alu_code_t ALU_AND   = 4'd3;
    localparam alu_code_t ALU_OR    = 4'd4;
    localparam alu_code_t ALU_SLT   = 4'd5;
    localparam alu_code_t ALU_MULT  = 4'd6;
    localparam alu_code_t ALU_DIV   = 4'd7;
    localparam alu_code_t ALU_MFHI  = 4'd8;
    localparam alu_code_t ALU_MFLO  = 4'd9;
    localparam alu_code_t ALU_XOR   = 4'd10;
    localparam alu_code_t ALU_NOR   = 4'd11;
    localparam alu_code_t ALU_SLTU  = 4'd12;
    localparam alu_code_t ALU_MULTU = 4'd13;
    localparam alu_code_t ALU_DIVU  = 4'd14;

    // Multiply/divide sequencer: idle, or an operation in flight.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Counter holds latency-1, latencies up to 64.
    localparam int CNT_W = $clog2(65);

endpackage

// File: rtl/libFunctions.sv
// Shared R-type function field codes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package libFunctions;

    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

endpackage

// File: rtl/alu_func_decoder.sv
// Combinational aluOp/func decode to ALU code plus mult/div/HI-LO class; ALU_EXT_FUNC_EN adds XOR/NOR/SLTU/MULTU/DIVU.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; gating by issue/stall is done by the caller.
module alu_func_decoder
    import libAlu::*;
    import libFunctions::*;
#(
    parameter int ALU_CTRL_W = 4
) (
    input  logic [1:0]            i_aluOp,
    input  logic [5:0]            i_func,
    output logic [ALU_CTRL_W-1:0] o_code,
    output logic                  o_is_mul,
    output logic                  o_is_div,
    output logic                  o_is_hilo
);

    alu_code_t w_code;

    // Map opcode class and function field to an operation and its class flags
    always_comb begin
        w_code    = ALU_ZERO;
        o_is_mul  = 1'b0;
        o_is_div  = 1'b0;
        o_is_hilo = 1'b0;
        case (i_aluOp)
            2'd1: begin
                case (i_func)
                    FN_ADD:  w_code = ALU_ADD;
                    FN_SUB:  w_code = ALU_SUB;
                    FN_AND:  w_code = ALU_AND;
                    FN_OR:   w_code = ALU_OR;
                    FN_SLT:  w_code = ALU_SLT;
                    FN_MULT: begin w_code = ALU_MULT; o_is_mul  = 1'b1; end
                    FN_DIV:  begin w_code = ALU_DIV;  o_is_div  = 1'b1; end
                    FN_MFHI: begin w_code = ALU_MFHI; o_is_hilo = 1'b1; end
                    FN_MFLO: begin w_code = ALU_MFLO; o_is_hilo = 1'b1; end
`ifdef ALU_EXT_FUNC_EN
                    FN_XOR:   w_code = ALU_XOR;
                    FN_NOR:   w_code = ALU_NOR;
                    FN_SLTU:  w_code = ALU_SLTU;
                    FN_MULTU: begin w_code = ALU_MULTU; o_is_mul = 1'b1; end
                    FN_DIVU:  begin w_code = ALU_DIVU;  o_is_div = 1'b1; end
`else
                    // Extended functions are unsupported in this build: no-op, never start the unit
                    FN_XOR, FN_NOR, FN_SLTU, FN_MULTU, FN_DIVU: w_code = ALU_ZERO;
`endif
                    default: w_code = ALU_ZERO;
                endcase
            end
            2'd2:    w_code = ALU_ADD;
            2'd3:    w_code = ALU_SUB;
            default: w_code = ALU_ZERO;
        endcase
    end

    assign o_code = ALU_CTRL_W'(w_code);

endmodule

// File: rtl/alu_control_sequencer.sv
// ALU control decode plus multi-cycle multiply/divide sequencer with HI/LO write strobe (ALU_EXT_FUNC_EN: extended funcs).
// Latency: aluControl combinational; regHiLoWrite N cycles after MULT/DIV acceptance (N = MULT_CYCLES or DIV_CYCLES).
// Backpressure: stall holds MULT/DIV while busy and MFHI/MFLO while a result is outstanding.
module alu_control_sequencer
    import libAlu::*;
#(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32,
    parameter int ALU_CTRL_W  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  issue,
    input  logic [1:0]            aluOp,
    input  logic [5:0]            func,
    output logic [ALU_CTRL_W-1:0] aluControl,
    output logic [ALU_CTRL_W-1:0] mdControl,
    output logic                  regHiLoWrite,
    output logic                  busy,
    output logic                  stall
);

    localparam logic [ALU_CTRL_W-1:0] CODE_ZERO = ALU_CTRL_W'(ALU_ZERO);
    localparam logic [CNT_W-1:0]      MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0]      DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    state_t                  r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic [ALU_CTRL_W-1:0]   r_md;

    logic [ALU_CTRL_W-1:0]   w_code;
    logic                    w_is_mul;
    logic                    w_is_div;
    logic                    w_is_hilo;
    logic                    w_run;
    logic                    w_accept;

    alu_func_decoder #(
        .ALU_CTRL_W (ALU_CTRL_W)
    ) u_dec (
        .i_aluOp   (aluOp),
        .i_func    (func),
        .o_code    (w_code),
        .o_is_mul  (w_is_mul),
        .o_is_div  (w_is_div),
        .o_is_hilo (w_is_hilo)
    );

    // Counter reaching zero marks the final (write) cycle; busy covers all earlier cycles
    assign w_run        = (r_state == RUN);
    assign busy         = w_run && (r_cnt != '0);
    assign regHiLoWrite = w_run && (r_cnt == '0);

    // HI/LO reads wait through the write cycle; a new MULT/DIV may start in the write cycle
    assign stall    = issue && (((w_is_mul || w_is_div) && busy) || (w_is_hilo && w_run));
    assign w_accept = issue && (w_is_mul || w_is_div) && !busy;

    assign aluControl = (issue && !stall) ? w_code : CODE_ZERO;
    assign mdControl  = r_md;

    // Sequencer: load latency on acceptance, count down, drop back to IDLE after the write cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_md    <= CODE_ZERO;
        end else if (w_accept) begin
            r_state <= RUN;
            r_cnt   <= w_is_mul ? MULT_LOAD : DIV_LOAD;
            r_md    <= w_code;
        end else if (w_run) begin
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end else begin
                r_state <= IDLE;
                r_md    <= CODE_ZERO;
            end
        end
    end

endmodule
